// File: rtl/gpr_mp.sv
// Multi-ported RV32 general purpose register file with same-cycle write bypass
// and a per-register pending-writeback scoreboard for long-latency results.
module gpr_mp #(
  parameter  int NUM_REGS = 32,   // 16 (RV32E) or 32 (RV32I)
  parameter  int XLEN     = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                             clk_in,
  input  logic                             reset_n_in,
  input  logic [NUM_RD-1:0][AW-1:0]        rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]      wr_data,
  input  logic [NUM_WR-1:0]                wr_clr,
  input  logic                             pend_set,
  input  logic [AW-1:0]                    pend_addr,
  output logic [CW-1:0]                    pend_cnt,
  output logic                             pend_err,
  output logic [NUM_REGS-1:0][XLEN-1:0]    gpr
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           pend_q, pend_d;
  logic [NUM_REGS-1:0]           clr_vec, set_vec;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          err_q, err_d;

  // Ports are scanned in ascending order so the highest-index port wins a collision.
  always_comb begin
    regs_d  = regs_q;
    clr_vec = '0;
    set_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w] != '0)) begin
        regs_d[wr_addr[w]] = wr_data[w];
        if (wr_clr[w]) clr_vec[wr_addr[w]] = 1'b1;
      end
    end
    if (pend_set && (pend_addr != '0)) set_vec[pend_addr] = 1'b1;
    // A new issue to the same register outranks its completing writeback.
    pend_d = (pend_q & ~clr_vec) | set_vec;
    err_d  = err_q | (|(set_vec & pend_q & ~clr_vec));
    cnt_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r] = regs_q[rd_addr[r]];
      rd_busy[r] = pend_q[rd_addr[r]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[r]) && (rd_addr[r] != '0)) begin
            rd_data[r] = wr_data[w];
            if (wr_clr[w]) rd_busy[r] = 1'b0;
          end
        end
      end
    end
  end

  assign gpr      = regs_q;
  assign pend_cnt = cnt_q;
  assign pend_err = err_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a bypassing and a non-bypassing instance share stimulus and
// are checked against an array-based reference model of the register file.
module tb_gpr_mp;

  localparam int NR = 32;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic                    clk_in;
  logic                    reset_n_in;
  logic [1:0][AW-1:0]      rd_addr;
  logic [1:0][XL-1:0]      rd_data_b, rd_data_n;
  logic [1:0]              rd_busy_b, rd_busy_n;
  logic [1:0]              wr_en;
  logic [1:0][AW-1:0]      wr_addr;
  logic [1:0][XL-1:0]      wr_data;
  logic [1:0]              wr_clr;
  logic                    pend_set;
  logic [AW-1:0]           pend_addr;
  logic [CW-1:0]           pend_cnt_b, pend_cnt_n;
  logic                    pend_err_b, pend_err_n;
  logic [NR-1:0][XL-1:0]   gpr_b, gpr_n;

  gpr_mp #(.NUM_REGS(NR), .XLEN(XL), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_byp (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_cnt(pend_cnt_b), .pend_err(pend_err_b), .gpr(gpr_b)
  );

  gpr_mp #(.NUM_REGS(NR), .XLEN(XL), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_nob (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .pend_cnt(pend_cnt_n), .pend_err(pend_err_n), .gpr(gpr_n)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Reference model state
  logic [XL-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_err;
  int            tests;
  int            fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NR; a++) begin
      m_regs[a] = '0;
      m_pend[a] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int a = 0; a < NR; a++) n += int'(m_pend[a]);
    return n;
  endfunction

  function automatic bit clearing(input int a);
    if (a == 0) return 1'b0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_clr[w] && int'(wr_addr[w]) == a) return 1'b1;
    return 1'b0;
  endfunction

  // Bypassed read: the newest (highest-index) enabled write to the address, else stored.
  function automatic logic [XL-1:0] exp_rd_byp(input int a);
    if (a == 0) return '0;
    for (int w = 1; w >= 0; w--)
      if (wr_en[w] && int'(wr_addr[w]) == a) return wr_data[w];
    return m_regs[a];
  endfunction

  function automatic bit exp_busy_byp(input int a);
    if (a == 0 || clearing(a)) return 1'b0;
    return m_pend[a];
  endfunction

  // Applies one clock edge worth of the register-file rules to the model.
  task automatic model_edge();
    bit do_set;
    int pa;
    bit clr [NR];
    do_set = pend_set && (pend_addr != '0);
    pa     = int'(pend_addr);
    for (int a = 0; a < NR; a++) clr[a] = clearing(a);
    if (do_set && m_pend[pa] && !clr[pa]) m_err = 1'b1;
    for (int a = 1; a < NR; a++) begin
      for (int w = 1; w >= 0; w--) begin
        if (wr_en[w] && int'(wr_addr[w]) == a) begin
          m_regs[a] = wr_data[w];
          break;
        end
      end
      if (do_set && a == pa) m_pend[a] = 1'b1;
      else if (clr[a])       m_pend[a] = 1'b0;
    end
  endtask

  task automatic check_state();
    for (int a = 0; a < NR; a++) begin
      chk($sformatf("gpr_byp[%0d]", a), gpr_b[a], m_regs[a]);
      chk($sformatf("gpr_nob[%0d]", a), gpr_n[a], m_regs[a]);
    end
    chk("pend_cnt_byp", pend_cnt_b, model_cnt());
    chk("pend_cnt_nob", pend_cnt_n, model_cnt());
    chk("pend_err_byp", pend_err_b, m_err);
    chk("pend_err_nob", pend_err_n, m_err);
  endtask

  // Checks combinational reads mid-cycle, clocks once, then checks state.
  task automatic cycle();
    #1;
    for (int r = 0; r < 2; r++) begin
      int a = int'(rd_addr[r]);
      chk($sformatf("rd_data_byp[%0d] a=%0d", r, a), rd_data_b[r], exp_rd_byp(a));
      chk($sformatf("rd_busy_byp[%0d] a=%0d", r, a), rd_busy_b[r], exp_busy_byp(a));
      chk($sformatf("rd_data_nob[%0d] a=%0d", r, a), rd_data_n[r], m_regs[a]);
      chk($sformatf("rd_busy_nob[%0d] a=%0d", r, a), rd_busy_n[r], m_pend[a]);
    end
    @(posedge clk_in);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
    pend_set = 1'b0; pend_addr = '0;
  endtask

  task automatic drive_wr(input int p, input int a, input logic [XL-1:0] d, input bit clr);
    wr_en[p]   = 1'b1;
    wr_addr[p] = AW'(a);
    wr_data[p] = d;
    wr_clr[p]  = clr;
  endtask

  task automatic drive_pend(input int a);
    pend_set  = 1'b1;
    pend_addr = AW'(a);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rd_addr    = '0;
    reset_n_in = 1'b0;
    model_reset();
    #12;
    check_state();
    reset_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Reset mid-operation: build up state, then drop reset between edges.
    drive_wr(0, 5, 32'hDEADBEEF, 1'b0); drive_pend(5); rd_addr[0] = 5;
    cycle();
    idle(); drive_pend(5);
    cycle();
    chk("pre_reset_gpr5", gpr_b[5], 32'hDEADBEEF);
    chk("pre_reset_err", pend_err_b, 1'b1);
    idle();
    #2 reset_n_in = 1'b0;
    #1;
    model_reset();
    chk("async_reset_gpr5", gpr_b[5], 32'h0);
    chk("async_reset_cnt", pend_cnt_b, 0);
    chk("async_reset_err", pend_err_b, 1'b0);
    check_state();
    @(posedge clk_in); #2;
    reset_n_in = 1'b1;

    // x0 is hardwired: writes, pend_set and busy all ignored.
    drive_wr(0, 0, 32'hFFFFFFFF, 1'b1); drive_pend(0); rd_addr = '0;
    cycle();
    idle();
    cycle();
    chk("x0_rd", rd_data_b[0], 32'h0);
    chk("x0_busy", rd_busy_b[0], 1'b0);
    chk("x0_cnt", pend_cnt_b, 0);

    // Write collision on x7; port 1 wins, visible same cycle with bypass.
    drive_wr(0, 7, 32'h11, 1'b0); drive_wr(1, 7, 32'h22, 1'b0); rd_addr[0] = 7;
    #1;
    chk("collision_byp_rd", rd_data_b[0], 32'h22);
    chk("collision_nob_rd", rd_data_n[0], 32'h0);
    cycle();
    chk("collision_gpr7", gpr_b[7], 32'h22);
    idle();
    cycle();

    // Non-bypassed read of x3 sees the new value one cycle late.
    drive_wr(0, 3, 32'h55, 1'b0); rd_addr[1] = 3;
    #1;
    chk("nobyp_same_cycle", rd_data_n[1], 32'h0);
    cycle();
    idle();
    #1;
    chk("nobyp_next_cycle", rd_data_n[1], 32'h55);
    cycle();

    // Scoreboard set and clearing writeback on x9.
    drive_pend(9); rd_addr[0] = 9;
    cycle();
    idle();
    #1;
    chk("sb_busy", rd_busy_b[0], 1'b1);
    chk("sb_cnt", pend_cnt_b, 1);
    cycle();
    drive_wr(1, 9, 32'hABCD, 1'b1);
    #1;
    chk("sb_clr_busy_byp", rd_busy_b[0], 1'b0);
    chk("sb_clr_data_byp", rd_data_b[0], 32'hABCD);
    chk("sb_clr_busy_nob", rd_busy_n[0], 1'b1);
    cycle();
    chk("sb_cnt_after", pend_cnt_b, 0);
    idle();

    // Set/clear race on x4, then a double issue raises the sticky error.
    drive_pend(4); rd_addr[0] = 4;
    cycle();
    drive_pend(4); drive_wr(0, 4, 32'h44, 1'b1);
    cycle();
    chk("race_cnt", pend_cnt_b, 1);
    chk("race_err", pend_err_b, 1'b0);
    idle(); drive_pend(4);
    cycle();
    chk("dbl_err", pend_err_b, 1'b1);
    idle();
    cycle();
    cycle();
    chk("dbl_err_sticky", pend_err_b, 1'b1);

    // Clean slate, then random traffic on a narrow address window to force overlaps.
    #2 reset_n_in = 1'b0;
    model_reset();
    @(posedge clk_in); #2;
    reset_n_in = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int w = 0; w < 2; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_addr[w] = AW'($urandom_range(0, 11));
        wr_data[w] = $urandom;
        wr_clr[w]  = ($urandom_range(0, 1) != 0);
      end
      pend_set  = ($urandom_range(0, 3) == 0);
      pend_addr = AW'($urandom_range(0, 11));
      rd_addr[0] = AW'($urandom_range(0, 11));
      rd_addr[1] = (n % 4 == 0) ? wr_addr[1] : AW'($urandom_range(0, 31));
      cycle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
